// File: rtl/gol_pkg.sv
// gol_pkg: frame geometry, row entry type and writeback FSM encoding
package gol_pkg;
   localparam int ROW_WIDTH = 1280;
   localparam int NUM_ROWS = 720;
   localparam int ADDR_W = 10;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] SWAP = 2'd2;
   typedef struct packed {
      logic [ADDR_W-1:0] row;
      logic [ROW_WIDTH-1:0] data;
   } row_t;
endpackage

// File: rtl/next_state_writeback_if.sv
// next_state_writeback_if: row input stream plus BRAM write port and status
interface next_state_writeback_if;
   import gol_pkg::*;
   logic in_valid;
   logic in_ready;
   logic [ADDR_W-1:0] in_row;
   logic [ROW_WIDTH-1:0] in_data;
   logic wr_grant;
   logic wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ROW_WIDTH-1:0] wr_data;
   logic wr_bank;
   logic frame_done;
   logic seq_err;
   logic err_clr;
   modport master (
      output in_valid, in_row, in_data, wr_grant, err_clr,
      input in_ready, wr_en, wr_addr, wr_data, wr_bank, frame_done, seq_err
   );
   modport slave (
      input in_valid, in_row, in_data, wr_grant, err_clr,
      output in_ready, wr_en, wr_addr, wr_data, wr_bank, frame_done, seq_err
   );
endinterface

// File: rtl/row_fifo.sv
// row_fifo: 2-entry FIFO with full/empty flags and simultaneous push/pop
module row_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2];
   logic wp, rp;
   logic [1:0] cnt;
   assign dout = mem[rp];
   assign full = cnt == 2'd2;
   assign empty = cnt == 2'd0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= 1'b0;
         rp <= 1'b0;
         cnt <= 2'd0;
      end else begin
         wp <= wp ^ push;
         rp <= rp ^ pop;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
endmodule

// File: rtl/next_state_writeback.sv
// next_state_writeback: buffers next-state rows, writes them to the frame BRAM,
// checks row order and flips the ping-pong bank at end of frame
module next_state_writeback
   import gol_pkg::*;
(
   input logic clk,
   input logic rst_n,
   next_state_writeback_if.slave bus
);
   logic [1:0] state, state_n;
   logic [ADDR_W-1:0] exp_row;
   logic full, empty, push, pop, last, f_push, f_pop, busy_n;
   row_t in_ent, fifo_out, head;
   assign in_ent = '{row: bus.in_row, data: bus.in_data};
   assign bus.in_ready = rst_n & !full & (state != SWAP);
   assign push = bus.in_valid & bus.in_ready;
   // An empty FIFO is bypassed so a granted row writes the cycle after accept
   assign pop = bus.wr_grant & (state != SWAP) & (!empty | push);
   assign head = empty ? in_ent : fifo_out;
   assign f_push = push & !(empty & pop);
   assign f_pop = pop & !empty;
   assign last = pop & (exp_row == ADDR_W'(NUM_ROWS - 1));
   assign busy_n = f_push | full | (!empty & !f_pop);
   assign state_n = (state == SWAP) ? (empty ? IDLE : ACTIVE) :
                    last ? SWAP : busy_n ? ACTIVE : IDLE;
   row_fifo #(.W($bits(row_t))) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (f_push),
      .pop   (f_pop),
      .din   (in_ent),
      .dout  (fifo_out),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         exp_row <= '0;
         bus.wr_en <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.wr_bank <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.seq_err <= 1'b0;
      end else begin
         state <= state_n;
         exp_row <= (state == SWAP) ? '0 : pop ? exp_row + 1'b1 : exp_row;
         bus.wr_en <= pop;
         if (pop) begin
            bus.wr_addr <= head.row;
            bus.wr_data <= head.data;
         end
         bus.frame_done <= last;
         bus.wr_bank <= bus.wr_bank ^ (state == SWAP);
         bus.seq_err <= (pop & (head.row != exp_row)) | (bus.seq_err & !bus.err_clr);
      end
endmodule
